// File: rtl/ss_xfer_pkg.sv
// Shared types and constants for the save-state transfer engine.
// Imported by the checksum unit and the top-level sequencer.
package ss_xfer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAVE_HALT,
    S_SAVE_READ,
    S_SAVE_PUSH,
    S_SAVE_SUM,
    S_LOAD_DATA,
    S_LOAD_CHECK,
    S_LOAD_WAIT
  } ss_state_e;

  localparam int SS_XFER_CSUM_SEED = 0;

endpackage

// File: rtl/ss_xfer_checksum.sv
// Running modular-sum checksum shared by the save and load paths.
// Clear has priority over accumulate; compare is combinational.
module ss_xfer_checksum
  import ss_xfer_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clear,
  input  logic                  i_acc,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [DATA_WIDTH-1:0] i_cmp,
  output logic [DATA_WIDTH-1:0] o_sum,
  output logic                  o_match
);

  localparam logic [DATA_WIDTH-1:0] SEED =
    DATA_WIDTH'(SS_XFER_CSUM_SEED);

  logic [DATA_WIDTH-1:0] r_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= SEED;
    end else if (i_clear) begin
      r_sum <= SEED;
    end else if (i_acc) begin
      r_sum <= r_sum + i_data;
    end
  end

  assign o_sum   = r_sum;
  assign o_match = (r_sum == i_cmp);

endmodule

// File: rtl/ss_transfer_engine.sv
// Save-state capture/restore sequencer between the core bus and the
// APF bridge streams, with checksum trailer and halt timeout.
module ss_transfer_engine
  import ss_xfer_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int WORD_COUNT   = 116,
  parameter int READ_LATENCY = 10,
  parameter int HALT_TIMEOUT = 4096
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic                  save_req,
  input  logic                  load_req,
  output logic                  save_ack,
  output logic                  save_busy,
  output logic                  save_ok,
  output logic                  save_err,
  output logic                  load_ack,
  output logic                  load_busy,
  output logic                  load_ok,
  output logic                  load_err,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  save_valid,
  input  logic                  save_ready,
  output logic [DATA_WIDTH-1:0] save_data,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_in,
  output logic                  bus_wren,
  output logic                  bus_reset_n,
  input  logic [DATA_WIDTH-1:0] bus_out,
  input  logic                  ss_ready,
  output logic                  ss_halt,
  output logic                  ss_reset
);

  localparam int TW = $clog2(HALT_TIMEOUT + 1);
  localparam int LW = $clog2(READ_LATENCY + 1);
  localparam logic [TW-1:0] T_MAX = TW'(HALT_TIMEOUT - 1);
  localparam logic [LW-1:0] L_MAX = LW'(READ_LATENCY);
  localparam logic [ADDR_WIDTH-1:0] A_LAST =
    ADDR_WIDTH'(WORD_COUNT - 1);

  ss_state_e r_state;
  ss_state_e w_next;

  logic                  r_save_req_d;
  logic                  r_load_req_d;
  logic                  w_save_rise;
  logic                  w_load_rise;
  logic [TW-1:0]         r_timer;
  logic [LW-1:0]         r_lat;
  logic [1:0]            r_commit;
  logic                  r_lpend;
  logic                  r_err;

  logic                  r_save_ack;
  logic                  r_save_busy;
  logic                  r_save_ok;
  logic                  r_save_err;
  logic                  r_load_ack;
  logic                  r_load_busy;
  logic                  r_load_ok;
  logic                  r_load_err;
  logic                  r_save_valid;
  logic [DATA_WIDTH-1:0] r_save_data;
  logic [ADDR_WIDTH-1:0] r_bus_addr;
  logic [DATA_WIDTH-1:0] r_bus_in;
  logic                  r_bus_wren;
  logic                  r_bus_reset_n;
  logic                  r_ss_reset;

  logic                  w_csum_clr;
  logic                  w_csum_acc;
  logic [DATA_WIDTH-1:0] w_csum_data;
  logic [DATA_WIDTH-1:0] w_sum;
  logic                  w_match;
  logic                  w_last;
  logic                  w_lat_done;
  logic                  w_load_ready;

  assign w_save_rise = save_req & ~r_save_req_d;
  assign w_load_rise = load_req & ~r_load_req_d;
  assign w_last      = (r_bus_addr == A_LAST);
  assign w_lat_done  = (r_lat == L_MAX);

  ss_xfer_checksum #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_csum (
    .clk    (clk_sys),
    .rst_n  (reset_n),
    .i_clear(w_csum_clr),
    .i_acc  (w_csum_acc),
    .i_data (w_csum_data),
    .i_cmp  (load_data),
    .o_sum  (w_sum),
    .o_match(w_match)
  );

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_csum_clr   = 1'b0;
    w_csum_acc   = 1'b0;
    w_csum_data  = load_data;
    w_load_ready = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_save_rise) begin
          w_next     = S_SAVE_HALT;
          w_csum_clr = 1'b1;
        end else if (load_valid) begin
          w_next     = S_LOAD_DATA;
          w_csum_clr = 1'b1;
        end
      end
      S_SAVE_HALT: begin
        if (ss_ready) begin
          w_next = S_SAVE_READ;
        end else if (r_timer == T_MAX) begin
          w_next = S_IDLE;
        end
      end
      S_SAVE_READ: begin
        w_csum_data = bus_out;
        if (w_lat_done) begin
          w_next     = S_SAVE_PUSH;
          w_csum_acc = 1'b1;
        end
      end
      S_SAVE_PUSH: begin
        if (save_ready) begin
          w_next = w_last ? S_SAVE_SUM : S_SAVE_READ;
        end
      end
      S_SAVE_SUM: begin
        if (save_ready) begin
          w_next = S_IDLE;
        end
      end
      S_LOAD_DATA: begin
        // the write cycle closes ready so each word gets its own bus slot
        w_load_ready = ~r_bus_wren;
        w_csum_acc   = ~r_bus_wren & load_valid;
        if (r_bus_wren && w_last) begin
          w_next = S_LOAD_CHECK;
        end
      end
      S_LOAD_CHECK: begin
        w_load_ready = 1'b1;
        if (load_valid) begin
          w_next = S_LOAD_WAIT;
        end
      end
      S_LOAD_WAIT: begin
        if (r_commit == 2'd2) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_save_req_d  <= 1'b0;
      r_load_req_d  <= 1'b0;
      r_timer       <= '0;
      r_lat         <= '0;
      r_commit      <= 2'd0;
      r_lpend       <= 1'b0;
      r_err         <= 1'b0;
      r_save_ack    <= 1'b0;
      r_save_busy   <= 1'b0;
      r_save_ok     <= 1'b0;
      r_save_err    <= 1'b0;
      r_load_ack    <= 1'b0;
      r_load_busy   <= 1'b0;
      r_load_ok     <= 1'b0;
      r_load_err    <= 1'b0;
      r_save_valid  <= 1'b0;
      r_save_data   <= '0;
      r_bus_addr    <= '0;
      r_bus_in      <= '0;
      r_bus_wren    <= 1'b0;
      r_bus_reset_n <= 1'b0;
      r_ss_reset    <= 1'b0;
    end else begin
      r_save_req_d  <= save_req;
      r_load_req_d  <= load_req;
      r_save_ack    <= 1'b0;
      r_load_ack    <= 1'b0;
      r_load_busy   <= 1'b0;
      r_ss_reset    <= 1'b0;
      r_bus_reset_n <= 1'b1;
      if (r_lpend) begin
        r_lpend    <= 1'b0;
        r_load_err <= 1'b1;
      end
      unique case (r_state)
        S_IDLE: begin
          r_bus_addr   <= '0;
          r_bus_wren   <= 1'b0;
          r_save_valid <= 1'b0;
          if (w_save_rise) begin
            r_save_ack  <= 1'b1;
            r_save_busy <= 1'b1;
            r_save_ok   <= 1'b0;
            r_save_err  <= 1'b0;
            r_load_ok   <= 1'b0;
            r_load_err  <= 1'b0;
            r_lpend     <= 1'b0;
            r_timer     <= '0;
          end else begin
            if (load_valid) begin
              r_err <= 1'b0;
            end
            if (w_load_rise) begin
              r_load_ack <= 1'b1;
              r_load_ok  <= 1'b0;
              r_lpend    <= 1'b1;
            end
          end
        end
        S_SAVE_HALT: begin
          if (ss_ready) begin
            r_lat <= '0;
          end else if (r_timer == T_MAX) begin
            r_save_busy <= 1'b0;
            r_save_err  <= 1'b1;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_SAVE_READ: begin
          if (w_lat_done) begin
            r_save_data  <= bus_out;
            r_save_valid <= 1'b1;
          end else begin
            r_lat <= r_lat + LW'(1);
          end
        end
        S_SAVE_PUSH: begin
          if (save_ready) begin
            if (w_last) begin
              r_save_data <= w_sum;
            end else begin
              r_save_valid <= 1'b0;
              r_bus_addr   <= r_bus_addr + ADDR_WIDTH'(1);
              r_lat        <= '0;
            end
          end
        end
        S_SAVE_SUM: begin
          if (save_ready) begin
            r_save_valid <= 1'b0;
            r_save_busy  <= 1'b0;
            r_save_ok    <= 1'b1;
          end
        end
        S_LOAD_DATA: begin
          if (r_bus_wren) begin
            r_bus_wren <= 1'b0;
            if (!w_last) begin
              r_bus_addr <= r_bus_addr + ADDR_WIDTH'(1);
            end
          end else if (load_valid) begin
            r_bus_in   <= load_data;
            r_bus_wren <= 1'b1;
          end
        end
        S_LOAD_CHECK: begin
          if (load_valid && !w_match) begin
            r_err <= 1'b1;
          end
        end
        S_LOAD_WAIT: begin
          unique case (r_commit)
            2'd0: begin
              if (w_load_rise) begin
                r_load_ack <= 1'b1;
                r_load_ok  <= 1'b0;
                r_load_err <= 1'b0;
                r_commit   <= 2'd1;
              end
            end
            2'd1: begin
              r_load_busy <= 1'b1;
              r_commit    <= 2'd2;
              if (r_err) begin
                r_bus_reset_n <= 1'b0;
              end else begin
                r_ss_reset <= 1'b1;
              end
            end
            default: begin
              r_commit <= 2'd0;
              if (r_err) begin
                r_load_err <= 1'b1;
              end else begin
                r_load_ok <= 1'b1;
              end
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  assign save_ack    = r_save_ack;
  assign save_busy   = r_save_busy;
  assign save_ok     = r_save_ok;
  assign save_err    = r_save_err;
  assign load_ack    = r_load_ack;
  assign load_busy   = r_load_busy;
  assign load_ok     = r_load_ok;
  assign load_err    = r_load_err;
  assign load_ready  = w_load_ready;
  assign save_valid  = r_save_valid;
  assign save_data   = r_save_data;
  assign bus_addr    = r_bus_addr;
  assign bus_in      = r_bus_in;
  assign bus_wren    = r_bus_wren;
  assign bus_reset_n = r_bus_reset_n;
  assign ss_halt     = (r_state != S_IDLE);
  assign ss_reset    = r_ss_reset;

endmodule

// File: tb/tb_ss_transfer_engine.sv
// Directed bench: save, backpressure, halt timeout, load ok/err,
// save-vs-load priority and asynchronous reset mid-load.
module tb_ss_transfer_engine;

  localparam int DW = 32;
  localparam int AW = 8;

  logic          clk_sys = 1'b0;
  logic          reset_n = 1'b0;
  logic          save_req = 1'b0;
  logic          load_req = 1'b0;
  logic          save_ack, save_busy, save_ok, save_err;
  logic          load_ack, load_busy, load_ok, load_err;
  logic          load_valid = 1'b0;
  logic          load_ready;
  logic [DW-1:0] load_data = '0;
  logic          save_valid;
  logic          save_ready = 1'b0;
  logic [DW-1:0] save_data;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_in;
  logic          bus_wren;
  logic          bus_reset_n;
  logic [DW-1:0] bus_out;
  logic          ss_ready = 1'b0;
  logic          ss_halt;
  logic          ss_reset;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] p0, p1, p2;
  logic [DW-1:0] cap[$];
  logic [AW-1:0] wr_a[$];
  logic [DW-1:0] wr_d[$];
  int            stall_bad;
  bit            save_done;

  always #5 clk_sys = ~clk_sys;

  ss_transfer_engine #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .WORD_COUNT  (4),
    .READ_LATENCY(3),
    .HALT_TIMEOUT(16)
  ) u_dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .save_req   (save_req),
    .load_req   (load_req),
    .save_ack   (save_ack),
    .save_busy  (save_busy),
    .save_ok    (save_ok),
    .save_err   (save_err),
    .load_ack   (load_ack),
    .load_busy  (load_busy),
    .load_ok    (load_ok),
    .load_err   (load_err),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .save_valid (save_valid),
    .save_ready (save_ready),
    .save_data  (save_data),
    .bus_addr   (bus_addr),
    .bus_in     (bus_in),
    .bus_wren   (bus_wren),
    .bus_reset_n(bus_reset_n),
    .bus_out    (bus_out),
    .ss_ready   (ss_ready),
    .ss_halt    (ss_halt),
    .ss_reset   (ss_reset)
  );

  // core bus model: addr + 0x100 returned after 3 clocks
  always @(posedge clk_sys) begin
    p0 <= 32'h100 + {24'h0, bus_addr};
    p1 <= p0;
    p2 <= p1;
  end
  assign bus_out = p2;

  always @(negedge clk_sys) begin
    if (reset_n && bus_wren) begin
      wr_a.push_back(bus_addr);
      wr_d.push_back(bus_in);
    end
  end

  function automatic logic [DW+AW*0+40-1:0] outs_all();
    return {save_ack, save_busy, save_ok, save_err,
            load_ack, load_busy, load_ok, load_err,
            load_ready, save_valid, bus_wren, bus_reset_n,
            ss_halt, ss_reset, save_data[7:0], bus_addr,
            bus_in[7:0], save_data[DW-1:8] != '0,
            bus_in[DW-1:8] != '0, 14'h0};
  endfunction

  task automatic do_save(input int stall_idx);
    logic [DW-1:0] hold;
    cap.delete();
    stall_bad = 0;
    save_done = 0;
    save_ready = 1'b1;
    @(posedge clk_sys); #1 save_req = 1'b1;
    @(posedge clk_sys); #1 save_req = 1'b0;
    for (int n = 0; n < 400 && !save_done; n++) begin
      @(negedge clk_sys);
      if (save_ok) begin
        save_done = 1;
      end else if (save_valid) begin
        if (cap.size() == stall_idx && save_ready) begin
          hold = save_data;
          save_ready = 1'b0;
          repeat (20) begin
            @(negedge clk_sys);
            if (save_data !== hold || bus_addr !== AW'(stall_idx)
                || save_valid !== 1'b1)
              stall_bad++;
          end
          save_ready = 1'b1;
        end
        cap.push_back(save_data);
      end
    end
  endtask

  task automatic feed(input logic [DW-1:0] d);
    bit got;
    got = 0;
    load_valid = 1'b1;
    load_data = d;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk_sys);
      if (load_ready) begin
        @(posedge clk_sys); #1;
        got = 1;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL feed_timeout: word %h not accepted", d);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #13;
    checks++;
    if (outs_all() !== '0) begin
      errors++;
      $display("FAIL reset_outs: got %h want 0", outs_all());
    end
    @(negedge clk_sys); reset_n = 1'b1;
    @(negedge clk_sys);
    checks++;
    if (bus_reset_n !== 1'b1 || ss_halt !== 1'b0) begin
      errors++;
      $display("FAIL idle_drive: bus_reset_n=%b ss_halt=%b want 1,0",
               bus_reset_n, ss_halt);
    end
  endtask

  task automatic test_idle_load_req();
    @(posedge clk_sys); #1 load_req = 1'b1;
    @(posedge clk_sys); #1 load_req = 1'b0;
    @(negedge clk_sys);
    checks++;
    if (load_ack !== 1'b1 || load_err !== 1'b0) begin
      errors++;
      $display("FAIL idle_lreq_ack: ack=%b err=%b want 1,0",
               load_ack, load_err);
    end
    @(negedge clk_sys);
    checks++;
    if (load_ack !== 1'b0 || load_err !== 1'b1) begin
      errors++;
      $display("FAIL idle_lreq_err: ack=%b err=%b want 0,1",
               load_ack, load_err);
    end
  endtask

  task automatic test_save();
    logic [DW-1:0] exp_w [5];
    exp_w = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h406};
    ss_ready = 1'b1;
    do_save(-1);
    checks++;
    if (!save_done || cap.size() != 5) begin
      errors++;
      $display("FAIL save_count: done=%0d words=%0d want 1,5",
               save_done, cap.size());
    end
    for (int i = 0; i < 5 && i < cap.size(); i++) begin
      checks++;
      if (cap[i] !== exp_w[i]) begin
        errors++;
        $display("FAIL save_word%0d: got %h want %h",
                 i, cap[i], exp_w[i]);
      end
    end
    checks++;
    if (save_ok !== 1'b1 || save_err !== 1'b0 || ss_halt !== 1'b0
        || save_busy !== 1'b0 || load_err !== 1'b0) begin
      errors++;
      $display("FAIL save_status: ok=%b err=%b halt=%b busy=%b lerr=%b",
               save_ok, save_err, ss_halt, save_busy, load_err);
    end
  endtask

  task automatic test_backpressure();
    do_save(2);
    checks++;
    if (stall_bad != 0) begin
      errors++;
      $display("FAIL bp_stable: %0d unstable cycles want 0", stall_bad);
    end
    checks++;
    if (cap.size() != 5 || cap[2] !== 32'h102 || cap[3] !== 32'h103
        || cap[4] !== 32'h406) begin
      errors++;
      $display("FAIL bp_stream: n=%0d w2=%h w3=%h sum=%h want 5,102,103,406",
               cap.size(), cap[2], cap[3], cap[4]);
    end
  endtask

  task automatic test_timeout();
    ss_ready = 1'b0;
    @(posedge clk_sys); #1 save_req = 1'b1;
    @(posedge clk_sys); #1 save_req = 1'b0;
    @(negedge clk_sys);
    checks++;
    if (save_ack !== 1'b1 || save_busy !== 1'b1 || ss_halt !== 1'b1
        || save_ok !== 1'b0) begin
      errors++;
      $display("FAIL to_start: ack=%b busy=%b halt=%b ok=%b want 1,1,1,0",
               save_ack, save_busy, ss_halt, save_ok);
    end
    repeat (15) @(negedge clk_sys);
    checks++;
    if (save_err !== 1'b0 || ss_halt !== 1'b1) begin
      errors++;
      $display("FAIL to_early: err=%b halt=%b want 0,1", save_err, ss_halt);
    end
    @(negedge clk_sys);
    checks++;
    if (save_err !== 1'b1 || ss_halt !== 1'b0 || save_busy !== 1'b0) begin
      errors++;
      $display("FAIL to_fire: err=%b halt=%b busy=%b want 1,0,0",
               save_err, ss_halt, save_busy);
    end
    ss_ready = 1'b1;
  endtask

  task automatic test_load(input logic [DW-1:0] trailer, input bit good);
    logic [DW-1:0] wv [4];
    wv = '{32'h0000000A, 32'h0000000B, 32'h0000000C, 32'hFFFFFFFF};
    wr_a.delete();
    wr_d.delete();
    @(posedge clk_sys); #1;
    for (int i = 0; i < 4; i++) feed(wv[i]);
    feed(trailer);
    load_valid = 1'b0;
    repeat (2) @(negedge clk_sys);
    checks++;
    if (wr_a.size() != 4 || load_ready !== 1'b0 || ss_halt !== 1'b1) begin
      errors++;
      $display("FAIL ld_wait: writes=%0d ready=%b halt=%b want 4,0,1",
               wr_a.size(), load_ready, ss_halt);
    end
    for (int i = 0; i < 4 && i < wr_a.size(); i++) begin
      checks++;
      if (wr_a[i] !== AW'(i) || wr_d[i] !== wv[i]) begin
        errors++;
        $display("FAIL ld_write%0d: got %h@%0d want %h@%0d",
                 i, wr_d[i], wr_a[i], wv[i], i);
      end
    end
    @(posedge clk_sys); #1 load_req = 1'b1;
    @(posedge clk_sys); #1 load_req = 1'b0;
    @(negedge clk_sys);
    checks++;
    if (load_ack !== 1'b1 || load_busy !== 1'b0) begin
      errors++;
      $display("FAIL ld_ack: ack=%b busy=%b want 1,0", load_ack, load_busy);
    end
    @(negedge clk_sys);
    checks++;
    if (load_ack !== 1'b0 || load_busy !== 1'b1 || ss_reset !== good
        || bus_reset_n !== good) begin
      errors++;
      $display("FAIL ld_commit: busy=%b ss_reset=%b bus_reset_n=%b want 1,%b,%b",
               load_busy, ss_reset, bus_reset_n, good, good);
    end
    @(negedge clk_sys);
    checks++;
    if (load_busy !== 1'b0 || ss_reset !== 1'b0 || bus_reset_n !== 1'b1
        || load_ok !== good || load_err !== !good || ss_halt !== 1'b0) begin
      errors++;
      $display("FAIL ld_done: ok=%b err=%b ssr=%b brn=%b halt=%b want %b,%b,0,1,0",
               load_ok, load_err, ss_reset, bus_reset_n, ss_halt,
               good, !good);
    end
  endtask

  task automatic test_priority();
    wr_a.delete();
    save_ready = 1'b1;
    @(posedge clk_sys); #1;
    save_req = 1'b1;
    load_valid = 1'b1;
    load_data = 32'h55;
    @(posedge clk_sys); #1;
    save_req = 1'b0;
    load_valid = 1'b0;
    @(negedge clk_sys);
    checks++;
    if (save_ack !== 1'b1 || save_busy !== 1'b1 || load_ready !== 1'b0) begin
      errors++;
      $display("FAIL prio_start: ack=%b busy=%b lready=%b want 1,1,0",
               save_ack, save_busy, load_ready);
    end
    save_done = 0;
    for (int n = 0; n < 200 && !save_done; n++) begin
      @(negedge clk_sys);
      if (save_ok) save_done = 1;
    end
    checks++;
    if (!save_done || wr_a.size() != 0) begin
      errors++;
      $display("FAIL prio_path: save_ok=%0d writes=%0d want 1,0",
               save_done, wr_a.size());
    end
  endtask

  task automatic test_reset_mid_load();
    bit at2;
    at2 = 0;
    @(posedge clk_sys); #1;
    feed(32'h1);
    feed(32'h2);
    for (int n = 0; n < 20 && !at2; n++) begin
      @(negedge clk_sys);
      if (bus_addr == AW'(2)) at2 = 1;
    end
    checks++;
    if (!at2) begin
      errors++;
      $display("FAIL rst_reach: bus_addr=%0d want 2", bus_addr);
    end
    #2 reset_n = 1'b0;
    load_valid = 1'b0;
    #1;
    checks++;
    if (outs_all() !== '0) begin
      errors++;
      $display("FAIL rst_mid: got %h want 0", outs_all());
    end
    @(negedge clk_sys); reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);
    checks++;
    if (ss_halt !== 1'b0 || load_ready !== 1'b0 || bus_reset_n !== 1'b1
        || bus_addr !== '0) begin
      errors++;
      $display("FAIL rst_idle: halt=%b ready=%b brn=%b addr=%0d want 0,0,1,0",
               ss_halt, load_ready, bus_reset_n, bus_addr);
    end
  endtask

  initial begin
    test_reset();
    test_idle_load_req();
    test_save();
    test_backpressure();
    test_timeout();
    test_load(32'h20, 1'b1);
    test_load(32'h21, 1'b0);
    test_priority();
    test_reset_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
